// File: rtl/soc2_uart_pkg.sv
// rtl/soc2_uart_pkg.sv - shared state encoding and oversampling constants for the UART receiver
package soc2_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } rx_state_t;

    localparam int OS_RATE      = 16;
    localparam int OS_MID_START = 7;
    localparam int OS_MID_BIT   = 15;
    localparam int DATA_BITS    = 8;

endpackage

// File: rtl/soc2_sync_fifo.sv
// rtl/soc2_sync_fifo.sv - circular-buffer FIFO with extra-bit pointers and combinational head
module soc2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/soc2_uart_rx_core.sv
// rtl/soc2_uart_rx_core.sv - oversampling 8N1 UART receiver with byte FIFO and error reporting
module soc2_uart_rx_core
    import soc2_uart_pkg::*;
#(
    parameter int CLK_DIV = 14,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             uart_rx,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [CNT_W-1:0] rx_count,
    output logic             frame_err,
    output logic             overrun,
    input  logic             err_clr
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       MID_START = 4'(OS_MID_START);
    localparam logic [3:0]       MID_BIT   = 4'(OS_MID_BIT);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    logic             rx_s1;
    logic             rxs;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       os;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    rx_state_t        state;
    logic             push_q;
    logic             fifo_full;
    logic             fifo_empty;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_s1     <= 1'b1;
            rxs       <= 1'b1;
            div_cnt   <= '0;
            os        <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            state     <= ST_IDLE;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1     <= uart_rx;
            rxs       <= rx_s1;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                os <= os + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    // Restart the divider so every later sample lands at a fixed offset from the edge.
                    if (!rxs) begin
                        state   <= ST_START;
                        os      <= '0;
                        div_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (tick && os == MID_START) begin
                        if (!rxs) begin
                            state   <= ST_DATA;
                            os      <= '0;
                            bit_idx <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick && os == MID_BIT) begin
                        shreg[bit_idx] <= rxs;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    if (tick && os == MID_BIT) begin
                        if (rxs) begin
                            push_q <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun <= 1'b0;
        end else if (push_q && fifo_full && !rx_ready) begin
            overrun <= 1'b1;
        end else if (err_clr) begin
            overrun <= 1'b0;
        end
    end

    soc2_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_q),
        .pop    (rx_ready),
        .din    (shreg),
        .dout   (rx_data),
        .count  (rx_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_soc2_uart_rx_core.sv
// tb/tb_soc2_uart_rx_core.sv - randomized self-checking bench for soc2_uart_rx_core
module tb_soc2_uart_rx_core;
    localparam int BIT = 32;

    logic       clk = 1'b0;
    logic       resetn;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         fe_cnt = 0;
    int         vcnt = 0;
    int         exp_fe;
    int         min_cnt;
    bit         rand_done;

    soc2_uart_rx_core #(
        .CLK_DIV (2),
        .DEPTH   (4),
        .CNT_W   (3)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (rx_valid) vcnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(BIT);
        end
        uart_rx = stop;
        idle(BIT);
        uart_rx = 1'b1;
    endtask

    task automatic clear_obs();
        got_q.delete();
        fe_cnt = 0;
        vcnt   = 0;
    endtask

    task automatic chk_popped(input string tag);
        chk({tag, "_n"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(tag, (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hdead, {24'h0, exp_q[i]});
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_count"}, rx_count, 0);
        chk({tag, "_ferr"}, frame_err, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_data"}, rx_data, 0);
    endtask

    initial begin
        resetn   = 1'b0;
        uart_rx  = 1'b1;
        rx_ready = 1'b1;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(20);

        // single good frame
        clear_obs();
        send_frame(8'h5A, 1'b1);
        idle(20);
        exp_q = '{8'h5A};
        chk_popped("t1_byte");
        chk("t1_valid_cycles", vcnt, 1);
        chk("t1_ferr", fe_cnt, 0);
        chk("t1_ovr", overrun, 0);
        chk("t1_count", rx_count, 0);

        // short glitch is rejected silently
        clear_obs();
        uart_rx = 1'b0;
        idle(8);
        uart_rx = 1'b1;
        idle(3 * BIT);
        chk("t2_pops", got_q.size(), 0);
        chk("t2_ferr", fe_cnt, 0);

        // bad stop bit, then a good frame
        clear_obs();
        send_frame(8'h3C, 1'b0);
        idle(40);
        chk("t3_ferr", fe_cnt, 1);
        chk("t3_pops", got_q.size(), 0);
        chk("t3_count", rx_count, 0);
        send_frame(8'h11, 1'b1);
        idle(20);
        exp_q = '{8'h11};
        chk_popped("t3_byte");
        chk("t3_ferr_after", fe_cnt, 1);

        // overflow with consumer stalled
        clear_obs();
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        idle(20);
        chk("t4_count", rx_count, 4);
        chk("t4_ovr", overrun, 1);
        chk("t4_head", rx_data, 8'h01);
        rx_ready = 1'b1;
        idle(10);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        chk_popped("t4_byte");
        chk("t4_count_drained", rx_count, 0);
        chk("t4_ovr_sticky", overrun, 1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        idle(1);
        chk("t4_ovr_clr", overrun, 0);

        // push into full FIFO with a simultaneous pop
        clear_obs();
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
        idle(10);
        chk("t5_count_full", rx_count, 4);
        min_cnt = 7;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                idle(307);
                rx_ready = 1'b1;
                idle(1);
                rx_ready = 1'b0;
            end
            begin
                for (int i = 0; i < 315; i++) begin
                    @(negedge clk);
                    if (int'(rx_count) < min_cnt) min_cnt = int'(rx_count);
                end
            end
        join
        idle(5);
        chk("t5_min_count", min_cnt, 4);
        chk("t5_count", rx_count, 4);
        chk("t5_ovr", overrun, 0);
        rx_ready = 1'b1;
        idle(10);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hA5};
        chk_popped("t5_byte");

        // reset in the middle of a frame
        rx_ready = 1'b0;
        send_frame(8'h66, 1'b1);
        idle(20);
        chk("t6_pre_count", rx_count, 1);
        fork
            send_frame(8'hC3, 1'b1);
            begin
                idle(5 * BIT + 10);
                resetn = 1'b0;
                @(negedge clk);
                chk_reset_outputs("t6_in_reset");
            end
        join
        idle(20);
        clear_obs();
        resetn   = 1'b1;
        rx_ready = 1'b1;
        idle(20);
        send_frame(8'h7E, 1'b1);
        idle(20);
        exp_q = '{8'h7E};
        chk_popped("t6_byte");
        chk("t6_ferr", fe_cnt, 0);
        chk("t6_ovr", overrun, 0);

        // random traffic against the frame-level model
        clear_obs();
        exp_q.delete();
        exp_fe    = 0;
        rand_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 24; f++) begin
                    logic [7:0] b;
                    logic       stop;
                    b    = 8'($urandom);
                    stop = ($urandom_range(0, 4) != 0);
                    send_frame(b, stop);
                    if (stop) exp_q.push_back(b);
                    else exp_fe++;
                    idle(stop ? $urandom_range(0, 40) : 8 + $urandom_range(0, 32));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    rx_ready = 1'($urandom_range(0, 1));
                    idle($urandom_range(1, 60));
                end
                rx_ready = 1'b1;
            end
        join
        idle(20);
        chk_popped("rnd_byte");
        chk("rnd_ferr", fe_cnt, exp_fe);
        chk("rnd_ovr", overrun, 0);
        chk("rnd_count", rx_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
